set_assoc_cache_ctrl: RTL and testbench
=======================================

Name: set_assoc_cache_ctrl

Overview:
Synthesizable, clocked tag/state controller for a parametrised N-way set-associative cache with true-LRU replacement. It is the next generation of the cache model: it adds a valid/ready request handshake, dirty bits, write-back or write-through mode, and a handshaked memory side for evict and refill. Data arrays are out of scope: the block tracks tags, valid, dirty and LRU state, and reports hit, way and statistics.

Parameters:
ADDR_W, 24, request address width
OFFSET_W, 3, block offset bits
SET_W, 3, set index bits (sets = 2**SET_W)
WAYS, 4, associativity; power of 2, >= 2
WRITE_BACK, 1, 1 = write-back write-allocate; 0 = write-through no-write-allocate
CNT_W, 32, statistics counter width
Derived: TAG_W = ADDR_W-SET_W-OFFSET_W; WAY_W = $clog2(WAYS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
rsp_valid  out  1  one-cycle response pulse
rsp_hit  out  1  response was a hit
rsp_way  out  WAY_W  way hit or installed
mem_valid  out  1  memory transaction request
mem_ready  in  1  memory accepts the transaction
mem_write  out  1  1 = writeback or write-through, 0 = refill read
mem_addr  out  ADDR_W  memory transaction address
hit_count  out  CNT_W  hits since reset
miss_count  out  CNT_W  misses since reset
wb_count  out  CNT_W  dirty evictions since reset

Behaviour:
- Address split: tag = [ADDR_W-1 : SET_W+OFFSET_W]; set = [SET_W+OFFSET_W-1 : OFFSET_W].
- Reset (async): all valid and dirty bits = 0; rank[s][w] = w; FSM to IDLE. All outputs = 0 except req_ready = 1. Reset mid-transaction drops mem_valid immediately and discards the request.
- FSM states: IDLE, LOOKUP, EVICT, REFILL, WTHRU, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, register write, addr, tag and set, then go to LOOKUP. req_ready = 0 in every other state.
- LOOKUP: compare all WAYS tags in parallel. Hit = valid && tag match.
  - Hit: hit_count++. Touch the LRU entry. Set dirty if req_write && WRITE_BACK. Go to WTHRU if req_write && !WRITE_BACK, else RESP.
  - Miss: miss_count++.
    - Write miss with WRITE_BACK = 0: go to WTHRU; no install, no LRU change.
    - Otherwise choose the victim: lowest-index invalid way, else the way with rank 0. Go to EVICT if the victim is valid && dirty, else REFILL.
- EVICT: mem_valid = 1, mem_write = 1, mem_addr = {victim tag, set, OFFSET_W'b0}. On mem_ready: wb_count++, go to REFILL.
- REFILL: mem_valid = 1, mem_write = 0, mem_addr = {req tag, set, 0}. On mem_ready: install tag, valid = 1, dirty = req_write && WRITE_BACK, touch LRU, go to RESP.
- WTHRU: mem_valid = 1, mem_write = 1, mem_addr = req_addr. On mem_ready, go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_hit and rsp_way (way 0 for a no-allocate write miss), then IDLE.
- Memory handshake: while mem_valid = 1, mem_write and mem_addr are held stable, and mem_valid is never retracted until mem_ready. mem_ready while mem_valid = 0 is ignored.
- LRU touch of way w with rank r: every way in the set with rank > r decrements; w gets rank WAYS-1. Ranks in a set always form a permutation of 0..WAYS-1.
- Latency: hit with no memory access gives rsp_valid 2 cycles after the accept edge. Each memory transaction adds (cycles until mem_ready) + 1.
- Counters saturate at all-ones and never wrap.

Test Plan:
1. Defaults, after reset: read 0x000040 (set 0, tag 1) -> REFILL with mem_addr 0x000040, rsp_hit = 0, rsp_way = 0. Repeat the read -> rsp_hit = 1, way 0, rsp_valid 2 cycles after accept; hit_count = 1, miss_count = 1.
2. Reads 0x40, 0x80, 0xC0, 0x100 fill ways 0-3. Read 0x40 (way 0 becomes MRU). Read 0x140 -> victim way 1 (tag 2); no EVICT, wb_count = 0.
3. WRITE_BACK = 1: write 0x40 (miss, dirty way 0), then reads 0x80, 0xC0, 0x100, 0x140 -> EVICT with mem_write = 1, mem_addr 0x000040, then REFILL 0x000140; wb_count = 1, rsp_way = 0.
4. Hold mem_ready = 0 for 5 cycles during REFILL -> mem_valid, mem_write and mem_addr stable throughout; req_ready = 0; rsp_valid once, 1 cycle after mem_ready.
5. WRITE_BACK = 0: write 0x200 -> miss, one WTHRU write at 0x200, no install. Then read 0x200 -> miss; miss_count = 2.
6. Drive rst_n low during REFILL -> mem_valid drops in the same cycle, all counters 0, req_ready = 1. Re-read the previously cached address -> miss.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// Tag/state controller for an N-way set-associative cache with true-LRU replacement,
// dirty tracking, write-back or write-through policy and a handshaked memory side.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int OFFSET_W   = 3,
  parameter int SET_W      = 3,
  parameter int WAYS       = 4,
  parameter int WRITE_BACK = 1,
  parameter int CNT_W      = 32,
  localparam int TAG_W     = ADDR_W - SET_W - OFFSET_W,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int SETS = 2**SET_W;
  localparam bit WB   = (WRITE_BACK != 0);

  typedef logic [WAYS-1:0][WAY_W-1:0] rank_row_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL, WTHRU, RESP} state_t;

  state_t                       state, state_nxt;
  logic                         req_write_q;
  logic [ADDR_W-1:0]            req_addr_q;
  logic [TAG_W-1:0]             tag_q;
  logic [SET_W-1:0]             set_q;
  logic [WAY_W-1:0]             way_q;
  logic                         hit_q;

  logic [TAG_W-1:0]             tag_mem [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]    valid_mem;
  logic [SETS-1:0][WAYS-1:0]    dirty_mem;
  rank_row_t                    rank_mem [SETS];

  logic                         hit_any, inv_any, victim_dirty, no_alloc;
  logic [WAY_W-1:0]             hit_way, inv_way, lru_way, victim_way;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Touched way becomes MRU; every way ranked above it slides down one place.
  function automatic rank_row_t lru_touch(input rank_row_t row, input logic [WAY_W-1:0] way);
    rank_row_t        r;
    logic [WAY_W-1:0] cur;
    r   = row;
    cur = row[way];
    for (int w = 0; w < WAYS; w++)
      if (row[w] > cur) r[w] = row[w] - WAY_W'(1);
    r[way] = WAY_W'(WAYS - 1);
    return r;
  endfunction

  assign tag_q    = req_addr_q[ADDR_W-1 -: TAG_W];
  assign set_q    = req_addr_q[SET_W+OFFSET_W-1 -: SET_W];
  assign no_alloc = req_write_q && !WB;

  // Descending scan so the lowest-index match wins for invalid-way selection.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_mem[set_q][w] && (tag_mem[set_q][w] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_mem[set_q][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (rank_mem[set_q][w] == '0) lru_way = WAY_W'(w);
    end
    victim_way   = inv_any ? inv_way : lru_way;
    victim_dirty = valid_mem[set_q][victim_way] && dirty_mem[set_q][victim_way];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_way   = '0;
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit_any)           state_nxt = no_alloc ? WTHRU : RESP;
        else if (no_alloc)     state_nxt = WTHRU;
        else if (victim_dirty) state_nxt = EVICT;
        else                   state_nxt = REFILL;
      end
      EVICT: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_mem[set_q][way_q], set_q, {OFFSET_W{1'b0}}};
        if (mem_ready) state_nxt = REFILL;
      end
      REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = {tag_q, set_q, {OFFSET_W{1'b0}}};
        if (mem_ready) state_nxt = RESP;
      end
      WTHRU: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_addr  = req_addr_q;
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_way   = way_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cache state and statistics; tags and request fields below carry no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem  <= '0;
      dirty_mem  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          rank_mem[s][w] <= WAY_W'(w);
    end else begin
      case (state)
        LOOKUP: begin
          if (hit_any) begin
            hit_count       <= sat_inc(hit_count);
            rank_mem[set_q] <= lru_touch(rank_mem[set_q], hit_way);
            if (req_write_q && WB) dirty_mem[set_q][hit_way] <= 1'b1;
          end else begin
            miss_count <= sat_inc(miss_count);
          end
        end
        EVICT: if (mem_ready) wb_count <= sat_inc(wb_count);
        REFILL: begin
          if (mem_ready) begin
            valid_mem[set_q][way_q] <= 1'b1;
            dirty_mem[set_q][way_q] <= req_write_q && WB;
            rank_mem[set_q]         <= lru_touch(rank_mem[set_q], way_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      req_write_q <= req_write;
      req_addr_q  <= req_addr;
    end
    if (state == LOOKUP) begin
      hit_q <= hit_any;
      if (hit_any)       way_q <= hit_way;
      else if (no_alloc) way_q <= '0;
      else               way_q <= victim_way;
    end
    if (state == REFILL && mem_ready) tag_mem[set_q][way_q] <= tag_q;
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: one write-back and one write-through instance
// sharing stimulus, selected by sel.
module tb_set_assoc_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, mem_ready = 1'b0;
  logic [23:0] req_addr = '0;

  logic        b_req_ready, b_rsp_valid, b_rsp_hit, b_mem_valid, b_mem_write;
  logic [1:0]  b_rsp_way;
  logic [23:0] b_mem_addr;
  logic [31:0] b_hit_count, b_miss_count, b_wb_count;
  logic        t_req_ready, t_rsp_valid, t_rsp_hit, t_mem_valid, t_mem_write;
  logic [1:0]  t_rsp_way;
  logic [23:0] t_mem_addr;
  logic [31:0] t_hit_count, t_miss_count, t_wb_count;

  set_assoc_cache_ctrl #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(b_req_ready), .req_write(req_write), .req_addr(req_addr),
    .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_way(b_rsp_way),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready & ~sel), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .hit_count(b_hit_count), .miss_count(b_miss_count), .wb_count(b_wb_count)
  );

  set_assoc_cache_ctrl #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(t_req_ready), .req_write(req_write), .req_addr(req_addr),
    .rsp_valid(t_rsp_valid), .rsp_hit(t_rsp_hit), .rsp_way(t_rsp_way),
    .mem_valid(t_mem_valid), .mem_ready(mem_ready & sel), .mem_write(t_mem_write), .mem_addr(t_mem_addr),
    .hit_count(t_hit_count), .miss_count(t_miss_count), .wb_count(t_wb_count)
  );

  wire        req_ready  = sel ? t_req_ready  : b_req_ready;
  wire        rsp_valid  = sel ? t_rsp_valid  : b_rsp_valid;
  wire        rsp_hit    = sel ? t_rsp_hit    : b_rsp_hit;
  wire [1:0]  rsp_way    = sel ? t_rsp_way    : b_rsp_way;
  wire        mem_valid  = sel ? t_mem_valid  : b_mem_valid;
  wire        mem_write  = sel ? t_mem_write  : b_mem_write;
  wire [23:0] mem_addr   = sel ? t_mem_addr   : b_mem_addr;
  wire [31:0] hit_count  = sel ? t_hit_count  : b_hit_count;
  wire [31:0] miss_count = sel ? t_miss_count : b_miss_count;
  wire [31:0] wb_count   = sel ? t_wb_count   : b_wb_count;

  int vectors = 0;
  int miscompares = 0;

  // Observations recorded by run_req for the scenario tasks to judge.
  int          mem_n;
  logic        mem_w [8];
  logic [23:0] mem_a [8];
  logic        unstable, busy_ready, got_hit, rsp_again, ready_after;
  logic [1:0]  got_way;
  int          got_lat;

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one request from IDLE, service memory with `stall` idle cycles per transaction,
  // and return one cycle after the response (back in IDLE).
  task automatic run_req(input logic wr, input logic [23:0] addr, input int stall);
    int   cyc, waitc;
    logic in_txn;
    mem_n = 0; unstable = 1'b0; busy_ready = 1'b0; got_lat = -1;
    got_hit = 1'bx; got_way = 2'bxx;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; in_txn = 1'b0; waitc = 0;
    while (cyc < 100) begin
      if (mem_ready) in_txn = 1'b0;
      mem_ready = 1'b0;
      if (rsp_valid) begin
        got_hit = rsp_hit; got_way = rsp_way; got_lat = cyc;
        break;
      end
      if (req_ready) busy_ready = 1'b1;
      if (mem_valid) begin
        if (!in_txn) begin
          if (mem_n < 8) begin mem_w[mem_n] = mem_write; mem_a[mem_n] = mem_addr; end
          mem_n++; in_txn = 1'b1; waitc = 0;
        end else if (mem_write !== mem_w[mem_n-1] || mem_addr !== mem_a[mem_n-1]) begin
          unstable = 1'b1;
        end
        mem_ready = (waitc >= stall);
        waitc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got_lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required a response", cyc);
    end
    @(posedge clk); #1;
    rsp_again = rsp_valid; ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready sel=%0d: got %b want 1", s, req_ready); end
      vectors++; if ({rsp_valid, rsp_hit, rsp_way} !== 4'b0) begin miscompares++; $display("FAIL rst_rsp sel=%0d: got %b want 0000", s, {rsp_valid, rsp_hit, rsp_way}); end
      vectors++; if ({mem_valid, mem_write, mem_addr} !== 26'h0) begin miscompares++; $display("FAIL rst_mem sel=%0d: got %h want 0", s, {mem_valid, mem_write, mem_addr}); end
      vectors++; if ({hit_count, miss_count, wb_count} !== 96'h0) begin miscompares++; $display("FAIL rst_counts sel=%0d: got %0d/%0d/%0d want 0/0/0", s, hit_count, miss_count, wb_count); end
    end
    sel = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_then_hit();
    sel = 1'b0; apply_reset();
    run_req(1'b0, 24'h000040, 0);
    vectors++; if (mem_n !== 1) begin miscompares++; $display("FAIL t1_miss_txns: got %0d want 1", mem_n); end
    vectors++; if ({mem_w[0], mem_a[0]} !== {1'b0, 24'h000040}) begin miscompares++; $display("FAIL t1_refill: got w=%b a=%h want w=0 a=000040", mem_w[0], mem_a[0]); end
    vectors++; if ({got_hit, got_way} !== 3'b000) begin miscompares++; $display("FAIL t1_miss_rsp: got hit=%b way=%0d want 0/0", got_hit, got_way); end
    run_req(1'b0, 24'h000040, 0);
    vectors++; if ({got_hit, got_way} !== 3'b100) begin miscompares++; $display("FAIL t1_hit_rsp: got hit=%b way=%0d want 1/0", got_hit, got_way); end
    vectors++; if (got_lat !== 2) begin miscompares++; $display("FAIL t1_hit_latency: got %0d want 2", got_lat); end
    vectors++; if (mem_n !== 0) begin miscompares++; $display("FAIL t1_hit_txns: got %0d want 0", mem_n); end
    vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin miscompares++; $display("FAIL t1_counts: got hit=%0d miss=%0d want 1/1", hit_count, miss_count); end
  endtask

  task automatic test_lru_replace();
    logic [23:0] fill [4];
    fill[0] = 24'h000040; fill[1] = 24'h000080; fill[2] = 24'h0000C0; fill[3] = 24'h000100;
    sel = 1'b0; apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, fill[i], 0);
      vectors++; if ({got_hit, got_way} !== {1'b0, i[1:0]}) begin miscompares++; $display("FAIL t2_fill%0d: got hit=%b way=%0d want 0/%0d", i, got_hit, got_way, i); end
    end
    run_req(1'b0, 24'h000040, 0);
    vectors++; if ({got_hit, got_way} !== 3'b100) begin miscompares++; $display("FAIL t2_touch: got hit=%b way=%0d want 1/0", got_hit, got_way); end
    run_req(1'b0, 24'h000140, 0);
    vectors++; if ({got_hit, got_way} !== 3'b001) begin miscompares++; $display("FAIL t2_victim: got hit=%b way=%0d want 0/1", got_hit, got_way); end
    vectors++; if (mem_n !== 1 || {mem_w[0], mem_a[0]} !== {1'b0, 24'h000140}) begin miscompares++; $display("FAIL t2_no_evict: got n=%0d w=%b a=%h want 1/0/000140", mem_n, mem_w[0], mem_a[0]); end
    vectors++; if (wb_count !== 32'd0) begin miscompares++; $display("FAIL t2_wb_count: got %0d want 0", wb_count); end
  endtask

  task automatic test_dirty_evict();
    sel = 1'b0; apply_reset();
    run_req(1'b1, 24'h000040, 0);
    vectors++; if ({got_hit, got_way} !== 3'b000 || mem_n !== 1 || mem_w[0] !== 1'b0) begin miscompares++; $display("FAIL t3_write_alloc: got hit=%b way=%0d n=%0d w=%b want 0/0/1/0", got_hit, got_way, mem_n, mem_w[0]); end
    run_req(1'b0, 24'h000080, 0);
    run_req(1'b0, 24'h0000C0, 0);
    run_req(1'b0, 24'h000100, 0);
    run_req(1'b0, 24'h000140, 0);
    vectors++; if (mem_n !== 2) begin miscompares++; $display("FAIL t3_txns: got %0d want 2", mem_n); end
    vectors++; if ({mem_w[0], mem_a[0]} !== {1'b1, 24'h000040}) begin miscompares++; $display("FAIL t3_evict: got w=%b a=%h want 1/000040", mem_w[0], mem_a[0]); end
    vectors++; if ({mem_w[1], mem_a[1]} !== {1'b0, 24'h000140}) begin miscompares++; $display("FAIL t3_refill: got w=%b a=%h want 0/000140", mem_w[1], mem_a[1]); end
    vectors++; if (wb_count !== 32'd1 || got_way !== 2'd0 || got_lat !== 4) begin miscompares++; $display("FAIL t3_result: got wb=%0d way=%0d lat=%0d want 1/0/4", wb_count, got_way, got_lat); end
  endtask

  task automatic test_mem_stall();
    sel = 1'b0; apply_reset();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL t4_idle_ready: got %b want 1", req_ready); end
    run_req(1'b0, 24'h000040, 5);
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL t4_stable: got unstable=%b want 0", unstable); end
    vectors++; if (busy_ready !== 1'b0) begin miscompares++; $display("FAIL t4_busy_ready: got %b want 0", busy_ready); end
    vectors++; if (mem_n !== 1 || mem_a[0] !== 24'h000040) begin miscompares++; $display("FAIL t4_txn: got n=%0d a=%h want 1/000040", mem_n, mem_a[0]); end
    vectors++; if (got_lat !== 8) begin miscompares++; $display("FAIL t4_latency: got %0d want 8", got_lat); end
    vectors++; if (rsp_again !== 1'b0 || ready_after !== 1'b1) begin miscompares++; $display("FAIL t4_single_rsp: got rsp=%b ready=%b want 0/1", rsp_again, ready_after); end
  endtask

  task automatic test_write_through();
    sel = 1'b1; apply_reset();
    run_req(1'b1, 24'h000200, 0);
    vectors++; if ({got_hit, got_way} !== 3'b000) begin miscompares++; $display("FAIL t5_wr_rsp: got hit=%b way=%0d want 0/0", got_hit, got_way); end
    vectors++; if (mem_n !== 1 || {mem_w[0], mem_a[0]} !== {1'b1, 24'h000200}) begin miscompares++; $display("FAIL t5_wthru: got n=%0d w=%b a=%h want 1/1/000200", mem_n, mem_w[0], mem_a[0]); end
    run_req(1'b0, 24'h000200, 0);
    vectors++; if (got_hit !== 1'b0 || mem_n !== 1 || {mem_w[0], mem_a[0]} !== {1'b0, 24'h000200}) begin miscompares++; $display("FAIL t5_rd_miss: got hit=%b n=%0d w=%b a=%h want 0/1/0/000200", got_hit, mem_n, mem_w[0], mem_a[0]); end
    vectors++; if (miss_count !== 32'd2 || hit_count !== 32'd0 || wb_count !== 32'd0) begin miscompares++; $display("FAIL t5_counts: got hit=%0d miss=%0d wb=%0d want 0/2/0", hit_count, miss_count, wb_count); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    sel = 1'b0; apply_reset();
    run_req(1'b0, 24'h000040, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (mem_valid !== 1'b1 || mem_addr !== 24'h000080) begin miscompares++; $display("FAIL t6_in_refill: got v=%b a=%h want 1/000080", mem_valid, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL t6_async_drop: got mem_valid=%b req_ready=%b want 0/1", mem_valid, req_ready); end
    vectors++; if ({hit_count, miss_count, wb_count} !== 96'h0) begin miscompares++; $display("FAIL t6_counts: got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_req(1'b0, 24'h000040, 0);
    vectors++; if (got_hit !== 1'b0 || miss_count !== 32'd1) begin miscompares++; $display("FAIL t6_reread: got hit=%b miss=%0d want 0/1", got_hit, miss_count); end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_lru_replace();
    test_dirty_evict();
    test_mem_stall();
    test_write_through();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
